// File: rtl/flag_streamer.sv
// flag_streamer: plays a writable message RAM onto LED cathodes, one word or one bit per display tick, PWM-dimmed.
// Latency: a tick updates shown on its clock edge; cats is decoded from registers only (no input-to-cats path).
// Backpressure: none; en=0 freezes tick counter and playback while the PWM keeps running.
// Ports: clk, rst (async active-high), en, mode (00 byte, 01 shift, 1x hold), brightness (PWM duty),
//        wr_en/wr_addr/wr_data (message RAM write port), cats (cathode drive), frame_done (message wrap pulse).
// Option: define FLAG_STREAMER_BLANK_GAP_EN to insert one blank frame after each message wrap.
module flag_streamer #(
    parameter int CLK_FREQ = 48_000_000,
    parameter int RATE_HZ  = 100,
    parameter int LED_W    = 8,
    parameter int MSG_LEN  = 45,
    parameter int PWM_BITS = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic [1:0]                 mode,
    input  logic [PWM_BITS-1:0]        brightness,
    input  logic                       wr_en,
    input  logic [$clog2(MSG_LEN)-1:0] wr_addr,
    input  logic [LED_W-1:0]           wr_data,
    output logic [LED_W-1:0]           cats,
    output logic                       frame_done
);
    localparam int TICK_DIV = CLK_FREQ / RATE_HZ;
    localparam int TW       = $clog2(TICK_DIV);
    localparam int AW       = $clog2(MSG_LEN);
    localparam int BW       = $clog2(LED_W);

    localparam logic [1:0] MODE_BYTE  = 2'b00;
    localparam logic [1:0] MODE_SHIFT = 2'b01;

    logic [LED_W-1:0]    mem [MSG_LEN];
    logic [TW-1:0]       tick_cnt;
    logic                tick;
    logic [AW-1:0]       idx, idx_nxt;
    logic [BW-1:0]       bit_idx, bit_idx_nxt;
    logic [LED_W-1:0]    shown, shown_nxt;
    logic [LED_W-1:0]    cur_word;
    logic                last_word;
    logic                wrap;
    logic                frame_done_nxt;
    logic [PWM_BITS-1:0] pwm_cnt, duty;
    logic                pwm_on;
`ifdef FLAG_STREAMER_BLANK_GAP_EN
    logic                gap, gap_nxt;   // a blank frame is owed before mem[0] plays again
`endif

    // Message RAM: plain registers, no reset. Reads are combinational from the
    // current contents, so a same-cycle write is only seen by later ticks.
    always_ff @(posedge clk) begin
        if (wr_en && ({1'b0, wr_addr} < (AW+1)'(MSG_LEN)))
            mem[wr_addr] <= wr_data;
    end

    assign cur_word  = mem[idx];
    assign last_word = (idx == AW'(MSG_LEN - 1));
    assign tick      = en && (tick_cnt == TW'(TICK_DIV - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            tick_cnt <= '0;
        else if (en)
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
    end

    always_comb begin
        idx_nxt        = idx;
        bit_idx_nxt    = bit_idx;
        shown_nxt      = shown;
        wrap           = 1'b0;
        frame_done_nxt = 1'b0;
`ifdef FLAG_STREAMER_BLANK_GAP_EN
        gap_nxt        = gap;
`endif
        if (tick) begin
`ifdef FLAG_STREAMER_BLANK_GAP_EN
            if (gap && mode == MODE_BYTE) begin
                shown_nxt      = '0;
                gap_nxt        = 1'b0;
                frame_done_nxt = 1'b1;
            end else if (gap && mode == MODE_SHIFT) begin
                // Shift a whole word of zeros, using bit_idx as the bit counter.
                shown_nxt = {shown[LED_W-2:0], 1'b0};
                if (bit_idx == '0) begin
                    bit_idx_nxt    = BW'(LED_W - 1);
                    gap_nxt        = 1'b0;
                    frame_done_nxt = 1'b1;
                end else begin
                    bit_idx_nxt = bit_idx - BW'(1);
                end
            end else
`endif
            if (mode == MODE_BYTE) begin
                shown_nxt = cur_word;
                idx_nxt   = last_word ? '0 : idx + AW'(1);
                wrap      = last_word;
            end else if (mode == MODE_SHIFT) begin
                shown_nxt = {shown[LED_W-2:0], cur_word[bit_idx]};
                if (bit_idx == '0) begin
                    bit_idx_nxt = BW'(LED_W - 1);
                    idx_nxt     = last_word ? '0 : idx + AW'(1);
                    wrap        = last_word;
                end else begin
                    bit_idx_nxt = bit_idx - BW'(1);
                end
            end
        end
        // Any non-shift cycle re-arms the bit pointer so a shift run starts on a word MSB.
        if (mode != MODE_SHIFT)
            bit_idx_nxt = BW'(LED_W - 1);
`ifdef FLAG_STREAMER_BLANK_GAP_EN
        if (wrap)
            gap_nxt = 1'b1;
`else
        frame_done_nxt = wrap;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            idx        <= '0;
            bit_idx    <= BW'(LED_W - 1);
            shown      <= '0;
            frame_done <= 1'b0;
`ifdef FLAG_STREAMER_BLANK_GAP_EN
            gap        <= 1'b0;
`endif
        end else begin
            idx        <= idx_nxt;
            bit_idx    <= bit_idx_nxt;
            shown      <= shown_nxt;
            frame_done <= frame_done_nxt;
`ifdef FLAG_STREAMER_BLANK_GAP_EN
            gap        <= gap_nxt;
`endif
        end
    end

    // Duty is only reloaded at the start of a PWM period so a brightness
    // change never produces a truncated or stretched on-pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pwm_cnt <= '0;
            duty    <= '0;
        end else begin
            pwm_cnt <= pwm_cnt + PWM_BITS'(1);
            if (pwm_cnt == '0)
                duty <= brightness;
        end
    end

    assign pwm_on = (pwm_cnt < duty);
    assign cats   = shown & {LED_W{pwm_on}};

endmodule

// File: tb/tb_flag_streamer.sv
`timescale 1ns/1ps
module tb_flag_streamer;
    localparam int CLK_FREQ = 1000;
    localparam int RATE_HZ  = 100;
    localparam int LED_W    = 8;
    localparam int MSG_LEN  = 4;
    localparam int PWM_BITS = 4;
    localparam int TICK_DIV = CLK_FREQ / RATE_HZ;
`ifdef FLAG_STREAMER_BLANK_GAP_EN
    localparam int BYTE_PERIOD = MSG_LEN + 1;
`else
    localparam int BYTE_PERIOD = MSG_LEN;
`endif

    logic                clk = 1'b0;
    logic                rst = 1'b1;
    logic                en = 1'b0;
    logic [1:0]          mode = 2'b00;
    logic [PWM_BITS-1:0] brightness = '0;
    logic                wr_en = 1'b0;
    logic [1:0]          wr_addr = '0;
    logic [LED_W-1:0]    wr_data = '0;
    logic [LED_W-1:0]    cats;
    logic                frame_done;

    always #5 clk = ~clk;

    flag_streamer #(
        .CLK_FREQ(CLK_FREQ), .RATE_HZ(RATE_HZ), .LED_W(LED_W),
        .MSG_LEN(MSG_LEN), .PWM_BITS(PWM_BITS)
    ) dut (
        .clk(clk), .rst(rst), .en(en), .mode(mode), .brightness(brightness),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .cats(cats), .frame_done(frame_done)
    );

    int n_checks = 0;
    int n_pass   = 0;
    logic [8:0] exp_q [$];   // {frame_done, shown} expected after each tick

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
    endtask

    task automatic write_word(input int a, input logic [7:0] d);
        wr_en   = 1'b1;
        wr_addr = 2'(a);
        wr_data = d;
        @(negedge clk);
        wr_en   = 1'b0;
    endtask

    // Called at a negedge; returns at the negedge where tick is high.
    task automatic wait_tick(output int c);
        c = 0;
        while (dut.tick !== 1'b1 && c <= 3 * TICK_DIV) begin
            @(negedge clk);
            c++;
        end
    endtask

    task automatic run_ticks(input int n, input int first_gap, input string tag);
        int c;
        logic [8:0] e;
        for (int i = 0; i < n; i++) begin
            wait_tick(c);
            if (c > 3 * TICK_DIV) begin
                check($sformatf("%s_tick_seen", tag), 32'(dut.tick), 32'd1);
                exp_q.delete();
                return;
            end
            if (i == 0 && first_gap >= 0)
                check($sformatf("%s_first_gap", tag), 32'(c), 32'(first_gap));
            if (i > 0)
                check($sformatf("%s_gap%0d", tag, i), 32'(c), 32'(TICK_DIV - 1));
            @(negedge clk);
            e = exp_q.pop_front();
            check($sformatf("%s_tick%0d", tag, i), 32'({frame_done, dut.shown}), 32'(e));
        end
    endtask

    task automatic count_on(input int n, output int on);
        on = 0;
        repeat (n) begin
            @(negedge clk);
            if (cats != '0) on++;
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0]  msg [MSG_LEN];
        logic [7:0]  w;
        logic        fd;
        logic [39:0] stream;
        logic [7:0]  s;
        int          c;
        int          on;
        int          levels [3];

        msg    = '{8'd67, 8'd72, 8'd65, 8'd76};
        levels = '{0, 8, 15};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_cats", 32'(cats), 32'd0);
        check("rst_frame_done", 32'(frame_done), 32'd0);
        check("rst_shown", 32'(dut.shown), 32'd0);
        check("rst_idx", 32'(dut.idx), 32'd0);
        check("rst_bit_idx", 32'(dut.bit_idx), 32'd7);
        check("rst_tick_cnt", 32'(dut.tick_cnt), 32'd0);
        check("rst_pwm_cnt", 32'(dut.pwm_cnt), 32'd0);
        rst = 1'b0;

        // Load message with en=0; tick counter must not move
        for (int i = 0; i < MSG_LEN; i++) write_word(i, msg[i]);
        check("idle_tick_cnt", 32'(dut.tick_cnt), 32'd0);

        // BYTE playback: one period plus one tick
        mode = 2'b00; brightness = 4'd15; en = 1'b1;
        for (int k = 0; k <= BYTE_PERIOD; k++) begin
`ifdef FLAG_STREAMER_BLANK_GAP_EN
            w  = (k < MSG_LEN) ? msg[k] : ((k == MSG_LEN) ? 8'd0 : msg[0]);
            fd = (k == MSG_LEN);
`else
            w  = msg[k % MSG_LEN];
            fd = (k == MSG_LEN - 1);
`endif
            exp_q.push_back({fd, w});
        end
        run_ticks(BYTE_PERIOD + 1, TICK_DIV - 1, "byte");
        c = 0;
        repeat (BYTE_PERIOD * TICK_DIV) begin
            @(negedge clk);
            if (frame_done === 1'b1) c++;
        end
        check("frame_done_per_period", 32'(c), 32'd1);

        // PWM brightness levels, display frozen on a nonzero word
        en = 1'b0;
        foreach (levels[i]) begin
            brightness = 4'(levels[i]);
            repeat (34) @(negedge clk);
            count_on(16, on);
            check($sformatf("pwm_on_%0d", levels[i]), 32'(on), 32'(levels[i]));
        end
        brightness = 4'd8;
        repeat (34) @(negedge clk);
        c = 0;
        while (dut.pwm_cnt !== 4'd5 && c < 20) begin
            @(negedge clk);
            c++;
        end
        check("pwm_phase", 32'(dut.pwm_cnt), 32'd5);
        brightness = 4'd15;
        count_on(10, on);   // pwm_cnt 6..15 still at duty 8
        check("pwm_mid_period", 32'(on), 32'd2);

`ifndef FLAG_STREAMER_BLANK_GAP_EN
        // SHIFT from a fresh reset, mem[0]=A5, through a full message wrap
        write_word(0, 8'hA5);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; mode = 2'b01; en = 1'b1;
        stream = {8'hA5, msg[1], msg[2], msg[3], 8'hA5};
        for (int k = 1; k <= 34; k++) begin
            s = 8'(stream >> (40 - k));
            exp_q.push_back({(k == 32), s});
        end
        run_ticks(8, TICK_DIV - 1, "shift_w0");
        check("shift_idx_after_word", 32'(dut.idx), 32'd1);
        check("shift_bit_idx_after_word", 32'(dut.bit_idx), 32'd7);
        run_ticks(24, TICK_DIV - 1, "shift_rest");
        check("shift_idx_wrapped", 32'(dut.idx), 32'd0);
        run_ticks(1, TICK_DIV - 1, "shift_after_wrap");

        // Freeze mid-tick for 25 clocks
        repeat (4) @(negedge clk);
        en = 1'b0;
        repeat (25) @(negedge clk);
        check("freeze_tick_cnt", 32'(dut.tick_cnt), 32'd4);
        check("freeze_shown", 32'(dut.shown), 32'(8'(stream >> 7)));
        check("freeze_idx", 32'(dut.idx), 32'd0);
        check("freeze_bit_idx", 32'(dut.bit_idx), 32'd6);
        en = 1'b1;
        run_ticks(1, 5, "resume");

        // HOLD: display frozen across a tick, tick counter keeps running
        mode = 2'b10;
        repeat (13) @(negedge clk);
        check("hold_tick_cnt", 32'(dut.tick_cnt), 32'd3);
        check("hold_shown", 32'(dut.shown), 32'(8'(stream >> 6)));
        check("hold_idx", 32'(dut.idx), 32'd0);
        check("hold_bit_idx", 32'(dut.bit_idx), 32'd7);

        // Write to the address being read on the same tick
        mode = 2'b00;
        exp_q.push_back({1'b0, 8'hA5});
        run_ticks(1, 6, "byte_restart");
        wait_tick(c);
        check("rbw_tick_gap", 32'(c), 32'(TICK_DIV - 1));
        check("rbw_idx", 32'(dut.idx), 32'd1);
        wr_en = 1'b1; wr_addr = 2'd1; wr_data = 8'h3C;
        @(negedge clk);
        wr_en = 1'b0;
        check("rbw_old_data", 32'({frame_done, dut.shown}), 32'({1'b0, msg[1]}));
        exp_q.push_back({1'b0, msg[2]});
        exp_q.push_back({1'b1, msg[3]});
        exp_q.push_back({1'b0, 8'hA5});
        exp_q.push_back({1'b0, 8'h3C});
        run_ticks(4, TICK_DIV - 1, "rbw_next_pass");

        // Async reset in the middle of a SHIFT word
        mode = 2'b01;
        s = 8'h3C;
        for (int j = 0; j < 2; j++) begin
            s = {s[6:0], msg[2][7 - j]};
            exp_q.push_back({1'b0, s});
        end
        run_ticks(2, TICK_DIV - 1, "shift_pre_rst");
        repeat (3) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_cats", 32'(cats), 32'd0);
        check("async_rst_shown", 32'(dut.shown), 32'd0);
        check("async_rst_idx", 32'(dut.idx), 32'd0);
        check("async_rst_bit_idx", 32'(dut.bit_idx), 32'd7);
        check("async_rst_tick_cnt", 32'(dut.tick_cnt), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_q.push_back({1'b0, 8'h01});
        exp_q.push_back({1'b0, 8'h02});
        exp_q.push_back({1'b0, 8'h05});
        run_ticks(3, TICK_DIV - 1, "shift_post_rst");
        check("post_rst_bit_idx", 32'(dut.bit_idx), 32'd4);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
